pfq: RTL

Prefetch queue feeding the execution control unit's instruction register. Fetches instruction bytes sequentially from an 8-bit memory port into a byte ring buffer and presents a little-endian 32-bit window starting at the current instruction address. The downstream instruction register accepts 1–4 bytes per instruction. A redirect (branch, call, reset vector) flushes the queue and restarts fetch at a new 16-bit address.

---
 rtl/pfq_pkg.sv | 17 +
 rtl/pfq_if.sv | 31 +++
 rtl/pfq_ring.sv | 64 ++++++
 rtl/pfq.sv | 117 +++++++++++
 4 files changed

// File: rtl/pfq_pkg.sv
// rtl/pfq_pkg.sv - shared types, defaults and length decode for the prefetch queue
package pfq_pkg;

  localparam int PFQ_DEPTH = 8;
  localparam int PFQ_AW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } pfq_state_t;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/pfq_if.sv
// rtl/pfq_if.sv - consumer, redirect and byte-memory signals of the prefetch queue
interface pfq_if
  import pfq_pkg::*;
#(
  parameter int DEPTH = PFQ_DEPTH,
  parameter int AW    = PFQ_AW
);

  logic                     redirect;
  logic [AW-1:0]            target;
  logic                     take;
  logic [1:0]               take_len;
  logic [31:0]              raw;
  logic [$clog2(DEPTH):0]   avail;
  logic [AW-1:0]            head_addr;
  logic                     mem_req;
  logic [AW-1:0]            mem_addr;
  logic                     mem_ack;
  logic [7:0]               mem_data;

  modport slave (
    input  redirect, target, take, take_len, mem_ack, mem_data,
    output raw, avail, head_addr, mem_req, mem_addr
  );

  modport master (
    output redirect, target, take, take_len, mem_ack, mem_data,
    input  raw, avail, head_addr, mem_req, mem_addr
  );

endinterface

// File: rtl/pfq_ring.sv
// rtl/pfq_ring.sv - byte ring buffer with push, multi-byte pop, flush and a zero-masked 4-byte window
module pfq_ring
  import pfq_pkg::*;
#(
  parameter int DEPTH = PFQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [7:0]             i_wdata,
  input  logic                   i_pop,
  input  logic [2:0]             i_pop_n,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [31:0]            o_window
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(i_pop_n);
      end
      r_count <= r_count + CW'(i_push) - (i_pop ? CW'(i_pop_n) : '0);
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_count > CW'(k)) begin
        o_window[8*k +: 8] = r_mem[PW'(r_rd_ptr + PW'(k))];
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pfq.sv
// rtl/pfq.sv - instruction prefetch queue: fetch FSM, address tracking and memory handshake
module pfq
  import pfq_pkg::*;
#(
  parameter int DEPTH = PFQ_DEPTH,
  parameter int AW    = PFQ_AW
) (
  input  logic  clk,
  input  logic  rst,
  pfq_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  pfq_state_t    r_state;
  logic [AW-1:0] r_fetch_addr;
  logic [AW-1:0] r_head_addr;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_req;

  logic [CW-1:0] w_count;
  logic [31:0]   w_window;
  logic [2:0]    w_take_n;
  logic [CW-1:0] w_take_cnt;
  logic          w_take_ok;
  logic          w_push;
  logic [CW-1:0] w_avail_next;
  logic          w_room_next;
  logic [AW-1:0] w_fetch_inc;

  assign w_take_n     = len_bytes(bus.take_len);
  assign w_take_cnt   = CW'(w_take_n);
  assign w_take_ok    = bus.take && !bus.redirect && (w_take_cnt <= w_count);
  assign w_push       = (r_state == ST_REQ) && bus.mem_ack && !bus.redirect;
  assign w_avail_next = w_count + CW'(w_push) - (w_take_ok ? w_take_cnt : '0);
  assign w_room_next  = (w_avail_next < CW'(DEPTH));
  assign w_fetch_inc  = r_fetch_addr + AW'(1);

  pfq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .rst_n    (rst),
    .i_flush  (bus.redirect),
    .i_push   (w_push),
    .i_wdata  (bus.mem_data),
    .i_pop    (w_take_ok),
    .i_pop_n  (w_take_n),
    .o_count  (w_count),
    .o_window (w_window)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= '0;
      r_head_addr  <= '0;
      r_mem_addr   <= '0;
      r_mem_req    <= 1'b0;
    end else begin
      if (bus.redirect) begin
        r_head_addr  <= bus.target;
        r_fetch_addr <= bus.target;
      end else if (w_take_ok) begin
        r_head_addr  <= r_head_addr + AW'(w_take_n);
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.redirect) begin
            r_state    <= ST_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= bus.target;
          end else if (w_room_next) begin
            r_state    <= ST_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_addr;
          end
        end
        ST_REQ: begin
          // A redirect that misses the ack leaves a bus transaction to drain in DROP.
          if (bus.redirect) begin
            if (bus.mem_ack) begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end else begin
              r_state   <= ST_DROP;
            end
          end else if (bus.mem_ack) begin
            r_fetch_addr <= w_fetch_inc;
            if (w_room_next) begin
              r_mem_addr <= w_fetch_inc;
            end else begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (!bus.redirect && bus.mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.raw       = w_window;
  assign bus.avail     = w_count;
  assign bus.head_addr = r_head_addr;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;

endmodule
